// File: rtl/axi4_burst_master.sv
// axi4_burst_master
//   AXI4 master issuing INCR bursts of 1..MAX_BURST beats on independent write and read paths.
//   Each path takes a command (address, beat count, start pulse) and exposes a zero-latency
//   valid/ready data stream toward user logic. Commands that would be zero length, too long or
//   cross a 4 KB boundary are rejected without any AXI activity.
//
// Ports
//   M_AXI_ACLK / M_AXI_ARESET   clock, asynchronous active-high reset
//   AMCI_W*                      write command, status and write data stream
//   AMCI_R*                      read command, status and read data stream
//   M_AXI_AW/W/B/AR/R*           AXI4 master interface (4-bit IDs)
module axi4_burst_master #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned MAX_BURST      = 256,
  parameter int unsigned AXI_ID         = 1,
  localparam int unsigned BW            = $clog2(MAX_BURST + 1)
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  // Write command / status / stream
  input  logic [AXI_ADDR_WIDTH-1:0]     AMCI_WADDR,
  input  logic [BW-1:0]                 AMCI_WBEATS,
  input  logic                          AMCI_WRITE,
  output logic                          AMCI_WIDLE,
  output logic [1:0]                    AMCI_WRESP,
  output logic                          AMCI_WERR,
  input  logic [AXI_DATA_WIDTH-1:0]     AMCI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   AMCI_WSTRB,
  input  logic                          AMCI_WDVALID,
  output logic                          AMCI_WDREADY,
  // Read command / status / stream
  input  logic [AXI_ADDR_WIDTH-1:0]     AMCI_RADDR,
  input  logic [BW-1:0]                 AMCI_RBEATS,
  input  logic                          AMCI_READ,
  output logic                          AMCI_RIDLE,
  output logic [1:0]                    AMCI_RRESP,
  output logic                          AMCI_RERR,
  output logic [AXI_DATA_WIDTH-1:0]     AMCI_RDATA,
  output logic                          AMCI_RDVALID,
  output logic                          AMCI_RDLAST,
  input  logic                          AMCI_RDREADY,
  // AXI write address
  output logic [3:0]                    M_AXI_AWID,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWLOCK,
  output logic [3:0]                    M_AXI_AWCACHE,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic [3:0]                    M_AXI_AWQOS,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  // AXI write data
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  // AXI write response
  input  logic [3:0]                    M_AXI_BID,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  // AXI read address
  output logic [3:0]                    M_AXI_ARID,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  // AXI read data
  input  logic [3:0]                    M_AXI_RID,
  input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int unsigned Bytes = AXI_DATA_WIDTH / 8;
  localparam int unsigned Size  = $clog2(Bytes);

  // Zero length, too long, or the last byte lands beyond the current 4 KB page.
  function automatic logic f_reject(input logic [11:0] addr_lo, input logic [BW-1:0] beats);
    logic [31:0] end_byte;
    end_byte = 32'(addr_lo) + 32'(beats) * 32'(Bytes);
    return (beats == '0) || (32'(beats) > 32'(MAX_BURST)) || (end_byte > 32'd4096);
  endfunction

  // Constant attributes
  assign M_AXI_AWID    = 4'(AXI_ID);
  assign M_AXI_AWSIZE  = 3'(Size);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'd2;
  assign M_AXI_AWPROT  = 3'b010;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_ARID    = 4'(AXI_ID);
  assign M_AXI_ARSIZE  = 3'(Size);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd2;
  assign M_AXI_ARPROT  = 3'b010;
  assign M_AXI_ARQOS   = 4'd0;

  // IDs are constant on this master, so responses are not filtered by ID.
  logic w_unused;
  assign w_unused = ^{M_AXI_BID, M_AXI_RID};

  // ---------------------------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {StWrIdle, StWrXfer, StWrResp} wr_state_e;
  wr_state_e r_wstate, w_wstate_next;

  logic [AXI_ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]                r_wlen, r_wcnt;
  logic                      r_aw_done, r_w_done, r_werr;
  logic [1:0]                r_wresp;
  logic w_wstart, w_wreject, w_in_wxfer, w_aw_fire, w_w_fire, w_wlast_fire, w_b_fire;

  assign w_wstart     = (r_wstate == StWrIdle) && AMCI_WRITE;
  assign w_wreject    = f_reject(AMCI_WADDR[11:0], AMCI_WBEATS);
  assign w_in_wxfer   = (r_wstate == StWrXfer);

  assign M_AXI_AWADDR  = r_waddr;
  assign M_AXI_AWLEN   = r_wlen;
  assign M_AXI_AWVALID = w_in_wxfer && !r_aw_done;
  // W stream is live for the whole XFER state until its last beat, independent of AW.
  assign M_AXI_WVALID  = w_in_wxfer && !r_w_done && AMCI_WDVALID;
  assign AMCI_WDREADY  = w_in_wxfer && !r_w_done && M_AXI_WREADY;
  assign M_AXI_WDATA   = AMCI_WDATA;
  assign M_AXI_WSTRB   = AMCI_WSTRB;
  assign M_AXI_WLAST   = (r_wcnt == r_wlen);
  assign M_AXI_BREADY  = (r_wstate == StWrResp);

  assign w_aw_fire    = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_fire     = M_AXI_WVALID && M_AXI_WREADY;
  assign w_wlast_fire = w_w_fire && M_AXI_WLAST;
  assign w_b_fire     = M_AXI_BVALID && M_AXI_BREADY;

  assign AMCI_WIDLE = (r_wstate == StWrIdle) && !AMCI_WRITE;
  assign AMCI_WRESP = r_wresp;
  assign AMCI_WERR  = r_werr;

  always_comb begin
    w_wstate_next = r_wstate;
    unique case (r_wstate)
      StWrIdle: if (w_wstart && !w_wreject) w_wstate_next = StWrXfer;
      StWrXfer: begin
        // AW and the last W beat may complete in either order or together.
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_wlast_fire)) w_wstate_next = StWrResp;
      end
      StWrResp: if (M_AXI_BVALID) w_wstate_next = StWrIdle;
      default:  w_wstate_next = StWrIdle;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) r_wstate <= StWrIdle;
    else              r_wstate <= w_wstate_next;
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_werr    <= 1'b0;
      r_wresp   <= 2'b00;
    end else begin
      if (w_wstart) begin
        if (w_wreject) begin
          r_werr  <= 1'b1;
          r_wresp <= 2'b10;
        end else begin
          r_waddr   <= AMCI_WADDR;
          r_wlen    <= 8'(AMCI_WBEATS - BW'(1));
          r_wcnt    <= '0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_werr    <= 1'b0;
          r_wresp   <= 2'b00;
        end
      end
      if (w_aw_fire) r_aw_done <= 1'b1;
      if (w_w_fire) begin
        r_wcnt <= r_wcnt + 8'd1;
        if (M_AXI_WLAST) r_w_done <= 1'b1;
      end
      if (w_b_fire) r_wresp <= M_AXI_BRESP;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------------
  typedef enum logic {StRdIdle, StRdXfer} rd_state_e;
  rd_state_e r_rstate, w_rstate_next;

  logic [AXI_ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]                r_rlen, r_rcnt;
  logic                      r_ar_done, r_rerr;
  logic [1:0]                r_rresp;
  logic w_rstart, w_rreject, w_in_rxfer, w_rdata_en, w_rcnt_last, w_ar_fire, w_r_fire, w_r_end;

  assign w_rstart    = (r_rstate == StRdIdle) && AMCI_READ;
  assign w_rreject   = f_reject(AMCI_RADDR[11:0], AMCI_RBEATS);
  assign w_in_rxfer  = (r_rstate == StRdXfer);
  // Data is only exchanged once the address has been accepted.
  assign w_rdata_en  = w_in_rxfer && r_ar_done;
  assign w_rcnt_last = (r_rcnt == r_rlen);

  assign M_AXI_ARADDR  = r_raddr;
  assign M_AXI_ARLEN   = r_rlen;
  assign M_AXI_ARVALID = w_in_rxfer && !r_ar_done;
  assign M_AXI_RREADY  = w_rdata_en && AMCI_RDREADY;
  assign AMCI_RDVALID  = w_rdata_en && M_AXI_RVALID;
  assign AMCI_RDATA    = M_AXI_RDATA;
  assign AMCI_RDLAST   = w_in_rxfer && w_rcnt_last;

  assign w_ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
  assign w_r_fire  = M_AXI_RVALID && M_AXI_RREADY;
  // Burst ends on whichever comes first: slave RLAST or our own final beat.
  assign w_r_end   = w_r_fire && (M_AXI_RLAST || w_rcnt_last);

  assign AMCI_RIDLE = (r_rstate == StRdIdle) && !AMCI_READ;
  assign AMCI_RRESP = r_rresp;
  assign AMCI_RERR  = r_rerr;

  always_comb begin
    w_rstate_next = r_rstate;
    unique case (r_rstate)
      StRdIdle: if (w_rstart && !w_rreject) w_rstate_next = StRdXfer;
      StRdXfer: if (w_r_end) w_rstate_next = StRdIdle;
      default:  w_rstate_next = StRdIdle;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) r_rstate <= StRdIdle;
    else              r_rstate <= w_rstate_next;
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_ar_done <= 1'b0;
      r_rerr    <= 1'b0;
      r_rresp   <= 2'b00;
    end else begin
      if (w_rstart) begin
        if (w_rreject) begin
          r_rerr  <= 1'b1;
          r_rresp <= 2'b10;
        end else begin
          r_raddr   <= AMCI_RADDR;
          r_rlen    <= 8'(AMCI_RBEATS - BW'(1));
          r_rcnt    <= '0;
          r_ar_done <= 1'b0;
          r_rerr    <= 1'b0;
          r_rresp   <= 2'b00;
        end
      end
      if (w_ar_fire) r_ar_done <= 1'b1;
      if (w_r_fire) begin
        r_rcnt <= r_rcnt + 8'd1;
        if (M_AXI_RRESP > r_rresp) r_rresp <= M_AXI_RRESP;
      end
      if (w_r_end && (M_AXI_RLAST != w_rcnt_last)) r_rerr <= 1'b1;
    end
  end

endmodule

// File: doc/axi4_burst_master.md
# axi4_burst_master

Parametrised AXI4 burst master, successor to the single-beat master: it issues INCR bursts of 1..MAX_BURST beats on independent write and read paths. Each path has a command port and a valid/ready data stream toward user logic. It also checks the 4 KB boundary and latches the worst-case response per burst. It sits between streaming datapath logic (DMA engines, frame movers) and an AXI4 interconnect.

## Interface
- AXI_DATA_WIDTH, 32: data bus width; power of two, 32..512.
- AXI_ADDR_WIDTH, 32: address width.
- MAX_BURST, 256: maximum beats per burst, 1..256.
- AXI_ID, 1: constant AWID/ARID.
- BW (localparam) = $clog2(MAX_BURST+1): width of the beat-count ports.
- M_AXI_ACLK  in  1  the single clock.
- M_AXI_ARESET  in  1  reset; asynchronous, active-high.
- AMCI_WADDR  in  AXI_ADDR_WIDTH  burst start address.
- AMCI_WBEATS  in  BW  beats in the write burst.
- AMCI_WRITE  in  1  one-cycle start pulse.
- AMCI_WIDLE  out  1  write path idle and no AMCI_WRITE pending.
- AMCI_WRESP  out  2  worst BRESP of the last burst.
- AMCI_WERR  out  1  last write command was rejected.
- AMCI_WDATA / AMCI_WSTRB  in  AXI_DATA_WIDTH / AXI_DATA_WIDTH/8  write beat data and strobes.
- AMCI_WDVALID  in  1 / AMCI_WDREADY  out  1  write stream handshake.
- AMCI_RADDR  in  AXI_ADDR_WIDTH / AMCI_RBEATS  in  BW / AMCI_READ  in  1  read command.
- AMCI_RIDLE  out  1 / AMCI_RRESP  out  2 / AMCI_RERR  out  1  read status, same meaning as the write equivalents. AMCI_RERR also flags an RLAST mismatch.
- AMCI_RDATA  out  AXI_DATA_WIDTH / AMCI_RDVALID  out  1 / AMCI_RDLAST  out  1 / AMCI_RDREADY  in  1  read stream.
- M_AXI_AW*, M_AXI_W*, M_AXI_B*, M_AXI_AR*, M_AXI_R*: full AXI4 master port set, standard widths; ID fields 4 bits.

## Operation
- Constant outputs:
  - AxID = AXI_ID; AxBURST = INCR (1); AxSIZE = $clog2(AXI_DATA_WIDTH/8).
  - AxCACHE = 2; AxPROT = 3'b010; AxLOCK = 0; AxQOS = 0.
  - AxLEN = beats-1, captured at command.
- Command rejection, for either path. A command is rejected when any of these holds:
  - beats == 0;
  - beats > MAX_BURST;
  - addr[11:0] + beats*(AXI_DATA_WIDTH/8) > 4096 (the burst would cross a 4 KB boundary).
- On rejection there is no AXI activity; xERR <= 1 and xRESP <= 2'b10. The path stays idle.
- Write FSM states: IDLE, XFER, RESP.
  - IDLE -> XFER on an accepted AMCI_WRITE. Capture address and length; clear beat counter, xERR, and the latched response.
  - In XFER, AWVALID is held until AWREADY. The W stream runs concurrently (W beats may precede AW acceptance):
    - M_AXI_WVALID = AMCI_WDVALID;
    - AMCI_WDREADY = M_AXI_WREADY;
    - WDATA/WSTRB pass through combinationally;
    - WLAST = (count == len).
  - XFER -> RESP once AW has been accepted and the last W beat has been accepted, in either order or in the same cycle. BREADY = 1 in RESP.
  - RESP -> IDLE on BVALID. AMCI_WRESP <= BRESP.
- Read FSM states: IDLE, XFER.
  - ARVALID is held until ARREADY.
  - RREADY = AMCI_RDREADY, and AMCI_RDVALID = RVALID, only after AR has been accepted; both are 0 otherwise.
  - RDATA passes through. AMCI_RDLAST = (count == len).
  - Each accepted beat does AMCI_RRESP <= max(AMCI_RRESP, RRESP).
  - XFER -> IDLE on the beat where RLAST is seen, or where count == len, whichever comes first.
  - If RLAST != (count == len) on that beat, set AMCI_RERR. The burst ends at the earlier of the two.
- AMCI_WRITE / AMCI_READ while the path is not idle: ignored, with no effect.

## Timing
- Reset (asynchronous, immediate) sets:
  - all xVALID, BREADY, RREADY, AMCI_WDREADY, AMCI_RDVALID = 0;
  - both FSMs to IDLE;
  - xRESP = 0, xERR = 0;
  - AMCI_WIDLE = AMCI_RIDLE = 1 when the start inputs are low.
- Reset mid-burst abandons the transaction immediately. No completion is reported.
- AWVALID/ARVALID rise on the clock edge after the command cycle (1 cycle latency). xIDLE drops combinationally in the command cycle.
- Data-stream paths are zero-latency combinational passthrough; no buffering.
- xIDLE rises the cycle after the final handshake (B for write, last R beat for read). xRESP and xERR are valid from that cycle until the next command.
- A rejected command yields xIDLE = 1 on the following cycle with xERR = 1.
- The write and read paths are fully independent and may run simultaneously.

## Test plan
- Write of 16 beats at 0x1000, 32-bit bus, slave AWREADY delayed 5 cycles and WREADY always 1 -> AWLEN = 15, AWSIZE = 2, 16 W beats with WLAST only on beat 16, AMCI_WRESP = 0, WIDLE rises one cycle after B.
- Write with WREADY toggled randomly and BRESP = 2'b10 -> every data word delivered in order, AMCI_WRESP = 2'b10, WERR = 0.
- Read of 256 beats at 0x0, with AMCI_RDREADY backpressure 50% -> 256 beats delivered, RDLAST on beat 256, RRESP = 0. Mid-burst RRESP = 2'b10 on one beat -> AMCI_RRESP = 2'b10.
- Rejections -> no AxVALID, xERR = 1, xRESP = 2'b10:
  - AMCI_WBEATS = 0;
  - write of 8 beats at 0x0FF0 (crosses 4 KB);
  - read of MAX_BURST+1 beats.
- Read with slave RLAST asserted on beat 3 of 4 -> burst ends at beat 3, AMCI_RERR = 1, RIDLE high next cycle.
- Assert M_AXI_ARESET during beat 5 of a 10-beat write -> WVALID/AWVALID/BREADY drop in the same cycle, WIDLE = 1 after release, and a following 2-beat write completes normally.
